// File: rtl/wrap_mon_pkg.sv
// Shared types and default sizes for the wrap event monitor.
package wrap_mon_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StTrack = 2'd1,
        StAlert = 2'd2
    } wrap_state_e;

    localparam int unsigned DEFAULT_WIDTH  = 8;
    localparam int unsigned DEFAULT_WRAP_W = 16;
    localparam int unsigned TS_W           = 32;

endpackage

// File: rtl/wrap_detect.sv
// Holds the previous count sample and flags a wrap when a new valid sample drops below it.
module wrap_detect #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] count_in,
    input  logic             count_valid,
    input  logic             armed,
    output logic             wrap
);

    logic [WIDTH-1:0] prev_q;

    // A discarded (cleared) sample must not become the comparison baseline.
    assign wrap = count_valid && armed && !clr && (count_in < prev_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else if (count_valid && !clr) begin
            prev_q <= count_in;
        end
    end

endmodule

// File: rtl/wrap_event_monitor.sv
// Counts wraps of an upstream counter and raises a sticky threshold interrupt.
// Define WRAP_MON_TIMESTAMP_EN to add a cycle counter and the last_wrap_ts capture port.
module wrap_event_monitor
    import wrap_mon_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned WRAP_W = DEFAULT_WRAP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              count_valid,
    input  logic [WRAP_W-1:0] thresh,
    input  logic              clr,
    input  logic              irq_ack,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              irq,
`ifdef WRAP_MON_TIMESTAMP_EN
    output logic [TS_W-1:0]   last_wrap_ts,
`endif
    output logic [1:0]        state
);

    localparam logic [WRAP_W-1:0] CntMax = '1;

    wrap_state_e       state_q;
    logic              armed;
    logic              wrap;
    logic              cnt_sat;
    logic [WRAP_W-1:0] cnt_inc;
    logic              crossing;

    assign state    = state_q;
    assign armed    = (state_q == StTrack) || (state_q == StAlert);
    assign cnt_sat  = (wrap_cnt == CntMax);
    assign cnt_inc  = wrap_cnt + WRAP_W'(1);
    // Only a real increment can cross; a saturated counter never re-fires the interrupt.
    assign crossing = wrap && !cnt_sat && (thresh != '0) && (cnt_inc == thresh);

    wrap_detect #(
        .WIDTH(WIDTH)
    ) u_detect (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .count_in   (count_in),
        .count_valid(count_valid),
        .armed      (armed),
        .wrap       (wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wrap_cnt   <= '0;
            wrap_pulse <= 1'b0;
            irq        <= 1'b0;
        end else if (clr) begin
            state_q    <= StIdle;
            wrap_cnt   <= '0;
            wrap_pulse <= 1'b0;
            irq        <= 1'b0;
        end else begin
            wrap_pulse <= wrap;
            if (wrap && !cnt_sat) begin
                wrap_cnt <= cnt_inc;
            end
            unique case (state_q)
                StIdle: begin
                    if (count_valid) begin
                        state_q <= StTrack;
                    end
                end
                StTrack: begin
                    if (crossing) begin
                        state_q <= StAlert;
                        irq     <= 1'b1;
                    end
                end
                StAlert: begin
                    if (!crossing && irq_ack) begin
                        state_q <= StTrack;
                        irq     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    irq     <= 1'b0;
                end
            endcase
        end
    end

`ifdef WRAP_MON_TIMESTAMP_EN
    logic [TS_W-1:0] cycle_q;

    // The cycle counter is free-running; clr only zeroes the captured stamp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q      <= '0;
            last_wrap_ts <= '0;
        end else begin
            cycle_q <= cycle_q + TS_W'(1);
            if (clr) begin
                last_wrap_ts <= '0;
            end else if (wrap) begin
                last_wrap_ts <= cycle_q;
            end
        end
    end
`endif

endmodule
